// File: rtl/gate_bist_ctrl.sv
// Exhaustive BIST sequencer for one combinational gate: sweeps every input vector,
// compares the gate output against a reduction-function golden model, and reports pass/fail.
module gate_bist_ctrl #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned OP     = 1,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_y,
  output logic [N_IN-1:0]  dut_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec
);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StCheck, StDone} state_e;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fail_valid_q, fail_valid_d;
  logic              pass_q, pass_d;
  logic              done_q, done_d;
  logic              entry_q, entry_d;
  logic              expected, mismatch, last;

  always_comb begin
    case (OP)
      0:       expected = &dut_in_q;
      1:       expected = |dut_in_q;
      2:       expected = ^dut_in_q;
      3:       expected = ~&dut_in_q;
      4:       expected = ~|dut_in_q;
      5:       expected = ~^dut_in_q;
      default: expected = 1'b0;
    endcase
  end

  // An unknown dut_y fails the equality test and is therefore counted as a mismatch.
  always_comb begin
    mismatch = 1'b1;
    if (dut_y == expected) mismatch = 1'b0;
  end

  assign last = (vec_q == {N_IN{1'b1}});

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    dut_in_d     = dut_in_q;
    fail_vec_d   = fail_vec_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;
    done_d       = 1'b0;
    entry_d      = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
          vec_d        = '0;
          state_d      = StDrive;
        end
      end
      StDrive: begin
        dut_in_d = vec_q;
        cnt_d    = '0;
        state_d  = (SETTLE > 0) ? StSettle : StCheck;
      end
      StSettle: begin
        if (cnt_q == 4'(SETTLE - 1)) state_d = StCheck;
        else                         cnt_d   = cnt_q + 4'd1;
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != {ERR_W{1'b1}}) err_d = err_q + 1'b1;
          if (!fail_valid_q) begin
            fail_vec_d   = dut_in_q;
            fail_valid_d = 1'b1;
          end
        end
        if (last) begin
          state_d = StDone;
          entry_d = 1'b1;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = StDrive;
        end
      end
      default: state_d = StIdle;
    endcase
    // Completion is reported one cycle after DONE entry so pass sees the final CHECK's count.
    if (entry_q) begin
      done_d = 1'b1;
      pass_d = (err_q == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      vec_q        <= '0;
      dut_in_q     <= '0;
      fail_vec_q   <= '0;
      cnt_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
      entry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      dut_in_q     <= dut_in_d;
      fail_vec_q   <= fail_vec_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
      entry_q      <= entry_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign busy       = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: a cycle-time model of the sweep checks the default instance every
// cycle; directed literal checks cover faults, timing, reset, restart and saturation.
module tb_gate_bist_ctrl;

  localparam int V = 4;   // vectors in the default sweep
  localparam int P = 3;   // cycles per vector (2 + SETTLE)
  localparam int VP = V * P;

  logic clk, rst;
  logic start_a, start_b, start_c;
  logic y_a, y_b, y_c;
  logic [1:0] din_a, din_c, fvec_a, fvec_c;
  logic [2:0] din_b, fvec_b;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic fv_a, fv_b, fv_c;
  logic [7:0] err_a, err_b;
  logic [0:0] err_c;

  int mode_a, mode_c;
  int checks, failures;

  // Gate behaviour: 0 = good, 1 = output stuck at 0, 2 = output stuck at 1.
  function automatic bit golden(input int op, input int v, input int n);
    int ones;
    bit r;
    ones = 0;
    for (int i = 0; i < n; i++) ones += (v >> i) & 1;
    case (op)
      0: r = (ones == n);
      1: r = (ones > 0);
      2: r = (ones % 2 == 1);
      3: r = (ones != n);
      4: r = (ones == 0);
      default: r = (ones % 2 == 0);
    endcase
    return r;
  endfunction

  function automatic bit gate_out(input int mode, input int op, input int v, input int n);
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return golden(op, v, n);
  endfunction

  assign y_a = gate_out(mode_a, 1, 32'(din_a), 2);
  assign y_b = gate_out(0, 2, 32'(din_b), 3);
  assign y_c = gate_out(mode_c, 1, 32'(din_c), 2);

  gate_bist_ctrl #(.N_IN(2), .OP(1), .SETTLE(1), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start_a), .dut_y(y_a), .dut_in(din_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .fail_valid(fv_a), .fail_vec(fvec_a)
  );

  gate_bist_ctrl #(.N_IN(3), .OP(2), .SETTLE(0), .ERR_W(8)) dut3 (
    .clk(clk), .rst(rst), .start(start_b), .dut_y(y_b), .dut_in(din_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .fail_valid(fv_b), .fail_vec(fvec_b)
  );

  gate_bist_ctrl #(.N_IN(2), .OP(1), .SETTLE(1), .ERR_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start_c), .dut_y(y_c), .dut_in(din_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .err_count(err_c), .fail_valid(fv_c), .fail_vec(fvec_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the default instance: cycles since the accepted start edge.
  bit trk;
  int t, hold, run_mode;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      trk <= 1'b0;
      t   <= 0;
      hold <= 0;
    end else begin
      if (start_a && (!trk || t >= VP)) begin
        trk      <= 1'b1;
        t        <= 0;
        hold     <= trk ? V - 1 : 0;
        run_mode <= mode_a;
      end else if (trk) begin
        t <= t + 1;
      end
    end
  end

  int m_in, m_err, m_fvec, m_comp;
  bit m_busy, m_done, m_pass, m_fv;

  always @(negedge clk) begin
    m_in = 0; m_err = 0; m_fvec = 0; m_fv = 0; m_busy = 0; m_done = 0; m_pass = 0;
    if (trk) begin
      m_busy = (t < VP);
      m_done = (t == VP + 1);
      if (t == 0) m_in = hold;
      else        m_in = ((t - 1) / P > V - 1) ? V - 1 : (t - 1) / P;
      m_comp = (t / P > V) ? V : t / P;
      for (int k = 0; k < m_comp; k++) begin
        if (gate_out(run_mode, 1, k, 2) != golden(1, k, 2)) begin
          if (m_err < 255) m_err++;
          if (!m_fv) begin
            m_fv = 1'b1;
            m_fvec = k;
          end
        end
      end
      m_pass = (t >= VP + 1) && (m_err == 0);
    end
    chk("model_dut_in", 32'(din_a), 32'(m_in));
    chk("model_busy", 32'(busy_a), 32'(m_busy));
    chk("model_done", 32'(done_a), 32'(m_done));
    chk("model_pass", 32'(pass_a), 32'(m_pass));
    chk("model_err", 32'(err_a), 32'(m_err));
    chk("model_fail_valid", 32'(fv_a), 32'(m_fv));
    chk("model_fail_vec", 32'(fvec_a), 32'(m_fvec));
  end

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0: return done_a;
      1: return done_b;
      default: return done_c;
    endcase
  endfunction

  // Pulses start, optionally re-pulses it on edge `repulse`, and watches 40 edges for done.
  task automatic run(input int which, input int repulse, output int first, output int npulse);
    first = -1;
    npulse = 0;
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(which, 1'b0);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (get_done(which)) begin
        npulse++;
        if (first < 0) first = e;
      end
      set_start(which, (e == repulse - 1) ? 1'b1 : 1'b0);
    end
  endtask

  int first, np;

  initial begin
    checks = 0; failures = 0;
    mode_a = 0; mode_c = 0;
    start_a = 0; start_b = 0; start_c = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dut_in", 32'(din_a), 32'd0);
    chk("reset_busy_done", {busy_a, done_a, pass_a, fv_a}, 32'd0);
    chk("reset_err", 32'(err_a), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(0, -1, first, np);
    chk("good_done_edge", 32'(first), 32'd13);
    chk("good_done_once", 32'(np), 32'd1);
    chk("good_pass", 32'(pass_a), 32'd1);
    chk("good_err", 32'(err_a), 32'd0);
    chk("good_fail_valid", 32'(fv_a), 32'd0);

    mode_a = 1;
    run(0, -1, first, np);
    chk("sa0_err", 32'(err_a), 32'd3);
    chk("sa0_fail_valid", 32'(fv_a), 32'd1);
    chk("sa0_fail_vec", 32'(fvec_a), 32'd1);
    chk("sa0_pass", 32'(pass_a), 32'd0);

    mode_a = 2;
    run(0, -1, first, np);
    chk("sa1_err", 32'(err_a), 32'd1);
    chk("sa1_fail_vec", 32'(fvec_a), 32'd0);
    chk("sa1_pass", 32'(pass_a), 32'd0);

    mode_a = 0;
    run(0, -1, first, np);
    chk("rerun_pass", 32'(pass_a), 32'd1);
    chk("rerun_err", 32'(err_a), 32'd0);

    // Reset mid-sweep, asserted between clock edges.
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_dut_in", 32'(din_a), 32'd0);
    chk("midrst_flags", {busy_a, done_a, pass_a, fv_a}, 32'd0);
    chk("midrst_err", 32'(err_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    np = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (done_a) np++;
    end
    chk("midrst_no_done", 32'(np), 32'd0);
    run(0, -1, first, np);
    chk("postrst_done_edge", 32'(first), 32'd13);
    chk("postrst_pass", 32'(pass_a), 32'd1);

    run(0, 4, first, np);
    chk("busy_start_done_edge", 32'(first), 32'd13);
    chk("busy_start_done_once", 32'(np), 32'd1);

    run(1, -1, first, np);
    chk("xor3_done_edge", 32'(first), 32'd17);
    chk("xor3_done_once", 32'(np), 32'd1);
    chk("xor3_pass", 32'(pass_b), 32'd1);
    chk("xor3_err", 32'(err_b), 32'd0);
    chk("xor3_last_vec", 32'(din_b), 32'd7);

    mode_c = 1;
    run(2, -1, first, np);
    chk("sat_err", 32'(err_c), 32'd1);
    chk("sat_fail_vec", 32'(fvec_c), 32'd1);
    chk("sat_pass", 32'(pass_c), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
